// File: rtl/counter_seq.sv
// Run-control sequencer owning a WIDTH-bit count register: start/stop, up/down, terminal value, pass count.
// Optional HOLD/pause support is compiled in with `define COUNTER_SEQ_PAUSE_EN.
module counter_seq #(
  parameter int WIDTH  = 4,
  parameter int LOOP_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              dir,
  input  logic [WIDTH-1:0]  limit,
  input  logic [LOOP_W-1:0] loops,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic [LOOP_W-1:0] loop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
`ifdef COUNTER_SEQ_PAUSE_EN
    ,
    HOLD = 2'd3
`endif
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  out_n, limit_q, limit_n, s_val, t_val;
  logic [LOOP_W-1:0] lc_n, loops_q, loops_n;
  logic              dir_q, dir_n, wrap_n, busy_n, done_n;

`ifndef COUNTER_SEQ_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause;
`endif

  assign s_val = dir_q ? limit_q : '0;
  assign t_val = dir_q ? '0 : limit_q;

  always_comb begin
    state_n = state;
    out_n   = out;
    lc_n    = loop_cnt;
    wrap_n  = 1'b0;
    dir_n   = dir_q;
    limit_n = limit_q;
    loops_n = loops_q;
    case (state)
      IDLE: begin
        if (start) begin
          dir_n   = dir;
          limit_n = limit;
          loops_n = loops;
          out_n   = dir ? limit : '0;
          lc_n    = '0;
          state_n = RUN;
        end
      end
`ifdef COUNTER_SEQ_PAUSE_EN
      RUN, HOLD: begin
`else
      RUN: begin
`endif
        if (stop) begin
          state_n = IDLE;
`ifdef COUNTER_SEQ_PAUSE_EN
        end else if (pause) begin
          state_n = HOLD;
`endif
        end else begin
          // Leaving HOLD steps on the same edge, so resume costs no extra cycle.
          state_n = RUN;
          if (out != t_val) begin
            out_n = dir_q ? out - 1'b1 : out + 1'b1;
          end else if (loop_cnt == loops_q) begin
            state_n = DONE;
            lc_n    = loop_cnt + 1'b1;
          end else begin
            out_n  = s_val;
            lc_n   = loop_cnt + 1'b1;
            wrap_n = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef COUNTER_SEQ_PAUSE_EN
    busy_n = (state_n == RUN) || (state_n == HOLD);
`else
    busy_n = (state_n == RUN);
`endif
    done_n = (state_n == DONE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      out      <= '0;
      loop_cnt <= '0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir_q    <= 1'b0;
      limit_q  <= '0;
      loops_q  <= '0;
    end else begin
      state    <= state_n;
      out      <= out_n;
      loop_cnt <= lc_n;
      wrap     <= wrap_n;
      busy     <= busy_n;
      done     <= done_n;
      dir_q    <= dir_n;
      limit_q  <= limit_n;
      loops_q  <= loops_n;
    end
  end

endmodule

// File: doc/counter_seq.md
# counter_seq

Run-control sequencer for the 4-bit 0–15 counter datapath. It owns the count register and adds start/stop control, up/down direction, a programmable terminal value and a programmable pass count. Status pulses mark wrap and completion. The block sits between the control/test logic and the counter display/consumer, so the counter is sequenced by commands rather than free-running.

## Interface
Parameters:
- WIDTH, 4, count width; `out` and `limit` use this width
- LOOP_W, 4, width of the `loops` and `loop_cnt` fields

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  single-cycle command; sampled only in IDLE
- stop  input  1  abort; sampled in RUN and HOLD
- pause  input  1  level; freezes counting while high (only when PAUSE is compiled in)
- dir  input  1  direction latched at start: 0 = up (0→limit), 1 = down (limit→0)
- limit  input  WIDTH  terminal value, latched at start
- loops  input  LOOP_W  extra passes, latched at start; total passes = loops+1
- out  output  WIDTH  count value, registered
- busy  output  1  high in RUN or HOLD
- wrap  output  1  one-cycle pulse, high while `out` shows the start value re-entered after a wrap
- done  output  1  one-cycle pulse in the DONE state
- loop_cnt  output  LOOP_W  number of completed passes in the current run

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset (async, RESET=0): state=IDLE; out=0; busy=0; wrap=0; done=0; loop_cnt=0; latched dir, limit and loops cleared to 0.
- Start value S = 0 when up, limit_q when down. Terminal value T = limit_q when up, 0 when down.
- IDLE:
  - `out` and `loop_cnt` hold their last values.
  - On start=1: latch dir, limit and loops; out←S; loop_cnt←0; go to RUN.
- RUN, evaluated each cycle in this priority order:
  1. stop=1: go to IDLE; `out` holds; no done.
  2. pause=1 (PAUSE compiled in): go to HOLD; `out` holds.
  3. out≠T: out←out+1 (up) or out−1 (down).
  4. out=T and loop_cnt=loops_q: go to DONE; `out` holds at T; loop_cnt←loop_cnt+1 (modulo 2^LOOP_W).
  5. out=T otherwise: out←S; loop_cnt←loop_cnt+1; wrap=1 next cycle.
- HOLD:
  - stop=1: go to IDLE.
  - pause=0: return to RUN; counting resumes from the held value.
  - Otherwise stay in HOLD with all outputs frozen.
- DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- start while in RUN, HOLD or DONE is ignored; the latched configuration does not change mid-run.
- start and stop together in IDLE: start wins (stop is not sampled in IDLE).
- limit_q=0: out=T every cycle, so each pass lasts one cycle. `wrap` stays high for consecutive cycles while passes remain.
- Arithmetic is unsigned and never leaves 0..limit_q. There is no overflow at 15: with limit=15 the counter wraps to S via rule 5 instead.

## Timing
- All outputs are registered, and all state changes occur on the rising CLK edge.
- Start latency: start high before edge k gives out=S and busy=1 after edge k. The first step occurs at edge k+1.
- A run from start to done takes (limit_q+1)·(loops_q+1) cycles in RUN, excluding HOLD cycles. done rises on the edge after the last T cycle, and busy falls on that same edge.
- stop latency: busy=0 after one edge.
- pause latency: the freeze takes effect on the first edge where pause is sampled high, and resume takes effect on the first edge where it is sampled low.
- Reset asserted mid-run forces the reset values immediately, without waiting for CLK. Deassertion takes effect at the next edge, and the block starts in IDLE.

## Configuration
- Macro: COUNTER_SEQ_PAUSE_EN.
- Defined: the HOLD state exists and `pause` behaves as described above.
- Undefined:
  - HOLD is not synthesized.
  - `pause` is ignored; the port remains, unused.
  - RUN applies the stop and counting rules only.

## Test plan
- Reset mid-run: RESET=0 asynchronously in RUN with out=7 → out=0, busy=0, loop_cnt=0 before the next edge. After release the block sits in IDLE.
- Up, single pass: limit=3, loops=0, dir=0, start → out sequence 0,1,2,3,3. done=1 in the 5th cycle after start, then busy=0. wrap is never high.
- Down, multiple passes: limit=2, loops=2, dir=1 → out sequence 2,1,0,2,1,0,2,1,0,0. wrap high on the 4th and 7th values. done once. loop_cnt ends at 3.
- Pause and stop (COUNTER_SEQ_PAUSE_EN defined): limit=15, up; pause high for 3 cycles at out=5 → out stays at 5 for 3 extra cycles, then 6. Asserting stop at out=9 → IDLE with out=9, no done.
- Edge cases: limit=0, loops=3 → out=0 throughout, wrap high for 3 consecutive cycles, then done. start pulsed during RUN → ignored, sequence unchanged.
- Macro undefined: the same pause stimulus has no effect, and out counts 5,6,7 continuously.
